mips_prog_loader: RTL and testbench

Byte-stream program loader that sits directly upstream of `pipe_MIPS32`. It receives a length-prefixed, checksummed program image over a valid/ready byte interface. It assembles big-endian 32-bit instruction words and writes them into the instruction/data memory from `BASE_ADDR` upward. Only after a clean load does it release the processor through `cpu_run`, which also clears the processor's HALTED, PC and TAKEN_BRANCH state.

---
 rtl/mips_loader_pkg.sv | 19 +
 rtl/mips_prog_loader_word_asm.sv | 36 +++
 rtl/mips_prog_loader.sv | 133 +++++++++++++
 tb/tb_mips_prog_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_loader_pkg.sv
// Shared definitions for the MIPS32 program loader: FSM states, image framing constants
// and the halt opcode that benches use to terminate generated programs.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [5:0] HLT = 6'h3f;

endpackage

// File: rtl/mips_prog_loader_word_asm.sv
// Big-endian word assembler: shifts accepted payload bytes in and flags the byte that completes a word.
module loader_word_asm
  import mips_loader_pkg::*;
(
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next_c,
  output logic        word_done_c
);

  localparam int unsigned CNT_W = 2;

  // Only the three earlier bytes need storing; the fourth arrives on the completing cycle.
  logic [23:0]      sr;
  logic [CNT_W-1:0] cnt;

  assign word_next_c = {sr, byte_in};
  assign word_done_c = shift_en && (cnt == CNT_W'(WORD_BYTES - 1));

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= word_next_c[23:0];
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mips_prog_loader.sv
// Length-prefixed, XOR-checksummed byte-stream loader that fills instruction memory
// and releases the pipelined MIPS32 core only after a clean load.
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  // Number of words that fit between BASE_ADDR and the top of memory.
  localparam int unsigned CAP = (32'd1 << ADDR_W) - BASE_ADDR;

  state_t      state;
  logic [15:0] len;
  logic [7:0]  csum;

  logic        accept_c;
  logic        shift_c;
  logic        asm_clr_c;
  logic [15:0] n_c;
  logic [15:0] words_inc_c;
  logic [31:0] word_next_c;
  logic        word_done_c;

  assign accept_c    = in_valid && in_ready;
  assign shift_c     = accept_c && (state == ST_DATA);
  assign asm_clr_c   = restart && ((state == ST_DONE) || (state == ST_ERR));
  assign n_c         = {len[15:8], in_data};
  assign words_inc_c = words_loaded + 16'd1;

  loader_word_asm u_word_asm (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .clr         (asm_clr_c),
    .shift_en    (shift_c),
    .byte_in     (in_data),
    .word_next_c (word_next_c),
    .word_done_c (word_done_c)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_LEN_HI;
      len          <= '0;
      csum         <= '0;
      in_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_run      <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_LEN_HI: begin
          if (accept_c) begin
            len[15:8] <= in_data;
            state     <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept_c) begin
            len[7:0] <= in_data;
            if (32'(n_c) > CAP) begin
              state    <= ST_ERR;
              load_err <= 1'b1;
              in_ready <= 1'b0;
            end else if (n_c == 16'd0) begin
              state <= ST_CHECK;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept_c) begin
            csum <= csum ^ in_data;
            if (word_done_c) begin
              mem_we       <= 1'b1;
              mem_addr     <= ADDR_W'(BASE_ADDR + 32'(words_loaded));
              mem_wdata    <= word_next_c;
              words_loaded <= words_inc_c;
              if (words_inc_c == len) begin
                state <= ST_CHECK;
              end
            end
          end
        end
        ST_CHECK: begin
          if (accept_c) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state   <= ST_DONE;
              cpu_run <= 1'b1;
            end else begin
              state    <= ST_ERR;
              load_err <= 1'b1;
            end
          end
        end
        ST_DONE, ST_ERR: begin
          if (restart) begin
            state        <= ST_LEN_HI;
            csum         <= '0;
            words_loaded <= '0;
            cpu_run      <= 1'b0;
            load_err     <= 1'b0;
            in_ready     <= 1'b1;
          end
        end
        default: begin
          state    <= ST_LEN_HI;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: framing, checksum, bounds, stalls, restart and async reset.
module tb_mips_prog_loader;
  import mips_loader_pkg::*;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic              clk1;
  logic              rst_n;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              restart;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_run;
  logic              load_err;
  logic [15:0]       words_loaded;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem [DEPTH];
  int          wr_count;

  mips_prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk1         (clk1),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .restart      (restart),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_run      (cpu_run),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Memory model fed by the write strobe, sampled mid-cycle.
  always @(negedge clk1) begin
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      wr_count      = wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h0;
    wr_count = 0;
  endtask

  // Called at a negedge; returns at the negedge after the byte transfers.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk1);
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk1);
    in_valid = 1'b0;
  endtask

  task automatic send_image(input logic [7:0] img[$], input int max_gap);
    foreach (img[i]) begin
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk1);
      send_byte(img[i]);
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk1);
    restart = 1'b0;
  endtask

  logic [7:0]  img[$];
  logic [7:0]  cs;
  logic [31:0] w;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    restart  = 1'b0;
    clear_model();
    repeat (2) @(negedge clk1);

    // Reset values
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    rst_n = 1'b1;
    @(negedge clk1);

    // Single word
    img = '{8'h00, 8'h01, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hFC};
    send_image(img, 0);
    check("w1_count", 32'(wr_count), 32'd1);
    check("w1_mem0", mem[0], 32'hFC000000);
    check("w1_cpu_run", 32'(cpu_run), 32'd1);
    check("w1_words", 32'(words_loaded), 32'd1);
    check("w1_in_ready", 32'(in_ready), 32'd0);
    pulse_restart();
    check("w1_rs_ready", 32'(in_ready), 32'd1);
    check("w1_rs_run", 32'(cpu_run), 32'd0);
    check("w1_rs_words", 32'(words_loaded), 32'd0);

    // Two words, with write-latency check on the first word
    clear_model();
    img = '{8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h0A};
    send_image(img, 0);
    check("w2_lat_we", 32'(mem_we), 32'd1);
    check("w2_lat_addr", 32'(mem_addr), 32'd0);
    check("w2_lat_data", mem_wdata, 32'h2801000A);
    check("w2_lat_words", 32'(words_loaded), 32'd1);
    img = '{8'hFC, 8'h00, 8'h00, 8'h00, 8'hDF};
    send_image(img, 0);
    check("w2_mem0", mem[0], 32'h2801000A);
    check("w2_mem1", mem[1], 32'hFC000000);
    check("w2_cpu_run", 32'(cpu_run), 32'd1);
    check("w2_words", 32'(words_loaded), 32'd2);
    pulse_restart();

    // Bad checksum
    clear_model();
    img = '{8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h0A, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00};
    send_image(img, 0);
    check("bad_count", 32'(wr_count), 32'd2);
    check("bad_mem1", mem[1], 32'hFC000000);
    check("bad_err", 32'(load_err), 32'd1);
    check("bad_run", 32'(cpu_run), 32'd0);
    check("bad_ready", 32'(in_ready), 32'd0);
    pulse_restart();
    check("bad_rs_err", 32'(load_err), 32'd0);
    check("bad_rs_ready", 32'(in_ready), 32'd1);

    // Oversize: 17 words into a 16-word memory
    clear_model();
    img = '{8'h00, 8'h11};
    send_image(img, 0);
    repeat (3) @(negedge clk1);
    check("big_err", 32'(load_err), 32'd1);
    check("big_ready", 32'(in_ready), 32'd0);
    check("big_count", 32'(wr_count), 32'd0);
    pulse_restart();

    // Exactly full memory (16 words) with random gaps
    clear_model();
    img = '{8'h00, 8'h10};
    cs  = 8'h00;
    for (int i = 0; i < 16; i++) begin
      w = {8'(i), 8'(i * 3 + 1), 8'(8'hA5 ^ 8'(i)), HLT, 2'b00};
      for (int k = 3; k >= 0; k--) begin
        img.push_back(w[k*8 +: 8]);
        cs ^= w[k*8 +: 8];
      end
    end
    img.push_back(cs);
    send_image(img, 3);
    check("full_run", 32'(cpu_run), 32'd1);
    check("full_words", 32'(words_loaded), 32'd16);
    check("full_count", 32'(wr_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      w = {8'(i), 8'(i * 3 + 1), 8'(8'hA5 ^ 8'(i)), HLT, 2'b00};
      check($sformatf("full_mem%0d", i), mem[i], w);
    end
    pulse_restart();

    // Empty image
    clear_model();
    img = '{8'h00, 8'h00, 8'h00};
    send_image(img, 0);
    check("empty_run", 32'(cpu_run), 32'd1);
    check("empty_words", 32'(words_loaded), 32'd0);
    check("empty_count", 32'(wr_count), 32'd0);
    pulse_restart();

    // Two words with gaps and an ignored restart mid-load
    clear_model();
    img = '{8'h00, 8'h02, 8'h28};
    send_image(img, 2);
    pulse_restart();
    img = '{8'h01, 8'h00, 8'h0A, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hDF};
    send_image(img, 4);
    check("gap_mem0", mem[0], 32'h2801000A);
    check("gap_mem1", mem[1], 32'hFC000000);
    check("gap_run", 32'(cpu_run), 32'd1);
    pulse_restart();

    // Async reset after two bytes of a word, then a fresh load
    clear_model();
    img = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_image(img, 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ready", 32'(in_ready), 32'd1);
    check("ar_we", 32'(mem_we), 32'd0);
    check("ar_words", 32'(words_loaded), 32'd0);
    check("ar_run", 32'(cpu_run), 32'd0);
    check("ar_err", 32'(load_err), 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
    check("ar_count", 32'(wr_count), 32'd0);
    img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_image(img, 0);
    check("ar_mem0", mem[0], 32'h12345678);
    check("ar_run2", 32'(cpu_run), 32'd1);
    check("ar_count2", 32'(wr_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
